// File: rtl/udma_ethernet_rx_ring_ctrl_pkg.sv
// Shared types and constants for the uDMA Ethernet RX ring controller.
package udma_ethernet_pkg;

  localparam int unsigned ETH_RX_SLOTS  = 4;
  localparam int unsigned ETH_RX_SLOT_W = $clog2(ETH_RX_SLOTS);
  localparam int unsigned DROP_CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT,
    ARM,
    RUN
  } rx_ring_state_e;

endpackage

// File: rtl/udma_ethernet_rx_ring_ctrl_if.sv
// Channel control, MAC frame events and completion publish bundle.
interface udma_ethernet_rx_ring_ctrl_if #(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16
);

  // uDMA channel control
  logic [L2_AWIDTH_NOAL-1:0] ch_startaddr_o;
  logic [TRANS_SIZE-1:0]     ch_size_o;
  logic                      ch_en_o;
  logic                      ch_clr_o;

  // MAC frame events
  logic                      frame_start_i;
  logic                      frame_valid_i;
  logic [TRANS_SIZE-1:0]     frame_len_i;

  // Completion publish towards the register interface
  logic [1:0]                rx_pointer_o;
  logic [TRANS_SIZE-1:0]     rx_size_o;
  logic                      frame_done_o;

  modport master (
    output ch_startaddr_o, ch_size_o, ch_en_o, ch_clr_o,
    output rx_pointer_o, rx_size_o, frame_done_o,
    input  frame_start_i, frame_valid_i, frame_len_i
  );

  modport slave (
    input  ch_startaddr_o, ch_size_o, ch_en_o, ch_clr_o,
    input  rx_pointer_o, rx_size_o, frame_done_o,
    output frame_start_i, frame_valid_i, frame_len_i
  );

endinterface

// File: rtl/udma_ethernet_rx_ring_ctrl.sv
// Walks the uDMA RX channel around a 4-slot buffer ring: arm, receive,
// publish completion, advance; stalls on software-owned slots.
module udma_ethernet_rx_ring_ctrl
  import udma_ethernet_pkg::*;
#(
  parameter int unsigned L2_AWIDTH_NOAL = 12,
  parameter int unsigned TRANS_SIZE     = 16,
  parameter int unsigned BUF_SIZE       = 1536
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_en_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_startaddr0_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_startaddr1_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_startaddr2_i,
  input  logic [L2_AWIDTH_NOAL-1:0]     cfg_startaddr3_i,
  input  logic [ETH_RX_SLOTS-1:0]       desc_full_i,
  output logic                          ring_stall_o,
  output logic [DROP_CNT_W-1:0]         drop_cnt_o,
  udma_ethernet_rx_ring_ctrl_if.master  rx_if
);

  localparam logic [TRANS_SIZE-1:0] BUF_SIZE_T = TRANS_SIZE'(BUF_SIZE);
  localparam logic [DROP_CNT_W-1:0] DROP_MAX   = '1;

  rx_ring_state_e             state_q, state_d;
  logic [ETH_RX_SLOT_W-1:0]   slot_q, slot_d;
  logic [ETH_RX_SLOT_W-1:0]   ptr_q, ptr_d;
  logic [TRANS_SIZE-1:0]      rx_size_q, rx_size_d;
  logic [L2_AWIDTH_NOAL-1:0]  ch_addr_q, ch_addr_d;
  logic [TRANS_SIZE-1:0]      ch_size_q, ch_size_d;
  logic                       ch_en_q, ch_en_d;
  logic                       ch_clr_q, ch_clr_d;
  logic                       done_q, done_d;
  logic                       stall_q, stall_d;
  logic [DROP_CNT_W-1:0]      drop_q, drop_d;

  logic [L2_AWIDTH_NOAL-1:0]  slot_addr;
  logic [TRANS_SIZE-1:0]      clipped_len;
  logic                       slot_owned;

  // Start address of the current slot
  always_comb begin
    unique case (slot_q)
      2'd0:    slot_addr = cfg_startaddr0_i;
      2'd1:    slot_addr = cfg_startaddr1_i;
      2'd2:    slot_addr = cfg_startaddr2_i;
      default: slot_addr = cfg_startaddr3_i;
    endcase
  end

  assign slot_owned  = desc_full_i[slot_q];
  assign clipped_len = (rx_if.frame_len_i > BUF_SIZE_T) ? BUF_SIZE_T : rx_if.frame_len_i;

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    ptr_d     = ptr_q;
    rx_size_d = rx_size_q;
    ch_addr_d = ch_addr_q;
    ch_size_d = ch_size_q;
    ch_en_d   = 1'b0;
    ch_clr_d  = 1'b0;
    done_d    = 1'b0;
    drop_d    = drop_q;

    // Frames starting while no buffer is armed are lost; count them
    if (cfg_en_i && rx_if.frame_start_i && (state_q == WAIT || state_q == CHECK)
        && drop_q != DROP_MAX) begin
      drop_d = drop_q + DROP_CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cfg_en_i) state_d = CHECK;
      end
      CHECK: begin
        if (!cfg_en_i)      state_d = IDLE;
        else if (slot_owned) state_d = WAIT;
        else                 state_d = ARM;
      end
      WAIT: begin
        if (!cfg_en_i)        state_d = IDLE;
        else if (!slot_owned) state_d = ARM;
      end
      ARM: begin
        if (!cfg_en_i) begin
          state_d = IDLE;
        end else begin
          ch_addr_d = slot_addr;
          ch_size_d = BUF_SIZE_T;
          ch_en_d   = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        // Completion is published even when the ring is being disabled
        if (rx_if.frame_valid_i) begin
          ptr_d     = slot_q;
          rx_size_d = clipped_len;
          done_d    = 1'b1;
          ch_clr_d  = 1'b1;
          slot_d    = slot_q + ETH_RX_SLOT_W'(1);
          state_d   = cfg_en_i ? CHECK : IDLE;
        end else if (!cfg_en_i) begin
          ch_clr_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    stall_d = (state_d == WAIT);
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      ptr_q     <= '1;
      rx_size_q <= '0;
      ch_addr_q <= '0;
      ch_size_q <= '0;
      ch_en_q   <= 1'b0;
      ch_clr_q  <= 1'b0;
      done_q    <= 1'b0;
      stall_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      ptr_q     <= ptr_d;
      rx_size_q <= rx_size_d;
      ch_addr_q <= ch_addr_d;
      ch_size_q <= ch_size_d;
      ch_en_q   <= ch_en_d;
      ch_clr_q  <= ch_clr_d;
      done_q    <= done_d;
      stall_q   <= stall_d;
      drop_q    <= drop_d;
    end
  end

  assign rx_if.ch_startaddr_o = ch_addr_q;
  assign rx_if.ch_size_o      = ch_size_q;
  assign rx_if.ch_en_o        = ch_en_q;
  assign rx_if.ch_clr_o       = ch_clr_q;
  assign rx_if.rx_pointer_o   = ptr_q;
  assign rx_if.rx_size_o      = rx_size_q;
  assign rx_if.frame_done_o   = done_q;
  assign ring_stall_o         = stall_q;
  assign drop_cnt_o           = drop_q;

endmodule

// File: tb/tb_udma_ethernet_rx_ring_ctrl.sv
// Directed bench for the uDMA Ethernet RX ring controller.
module tb_udma_ethernet_rx_ring_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_en;
  logic [11:0] addr0, addr1, addr2, addr3;
  logic [3:0]  desc_full;
  logic        ring_stall;
  logic [7:0]  drop_cnt;

  int tests_run    = 0;
  int tests_failed = 0;
  int both_pulses  = 0;

  udma_ethernet_rx_ring_ctrl_if #(.L2_AWIDTH_NOAL(12), .TRANS_SIZE(16)) rx_if ();

  udma_ethernet_rx_ring_ctrl #(
    .L2_AWIDTH_NOAL(12),
    .TRANS_SIZE    (16),
    .BUF_SIZE      (1536)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .cfg_en_i        (cfg_en),
    .cfg_startaddr0_i(addr0),
    .cfg_startaddr1_i(addr1),
    .cfg_startaddr2_i(addr2),
    .cfg_startaddr3_i(addr3),
    .desc_full_i     (desc_full),
    .ring_stall_o    (ring_stall),
    .drop_cnt_o      (drop_cnt),
    .rx_if           (rx_if.master)
  );

  always #5 clk = ~clk;

  // Arm and clear must never coincide
  always @(negedge clk) begin
    if (rx_if.ch_en_o === 1'b1 && rx_if.ch_clr_o === 1'b1) both_pulses++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [15:0] len);
    rx_if.frame_valid_i = 1'b1;
    rx_if.frame_len_i   = len;
    step(1);
    rx_if.frame_valid_i = 1'b0;
    rx_if.frame_len_i   = 16'd0;
  endtask

  // Returns the number of cycles until ch_en_o is seen, or -1 after 8 cycles
  task automatic wait_arm(output int n);
    n = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1);
      if (rx_if.ch_en_o === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(2);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'b11 || rx_if.rx_size_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_publish: ptr=%0d size=%0d, required ptr=3 size=0",
               rx_if.rx_pointer_o, rx_if.rx_size_o);
    end
    tests_run++;
    if (rx_if.ch_en_o !== 1'b0 || rx_if.ch_clr_o !== 1'b0 || rx_if.frame_done_o !== 1'b0 ||
        ring_stall !== 1'b0 || drop_cnt !== 8'd0 || rx_if.ch_startaddr_o !== 12'h0 ||
        rx_if.ch_size_o !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: en=%b clr=%b done=%b stall=%b drop=%0d addr=%h size=%0d, required all zero",
               rx_if.ch_en_o, rx_if.ch_clr_o, rx_if.frame_done_o, ring_stall, drop_cnt,
               rx_if.ch_startaddr_o, rx_if.ch_size_o);
    end
  endtask

  task automatic test_first_arm();
    rst    = 1'b0;
    cfg_en = 1'b1;
    step(2);
    tests_run++;
    if (rx_if.ch_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_arm_early: ch_en=%b, required 0", rx_if.ch_en_o);
    end
    step(1);
    tests_run++;
    if (rx_if.ch_en_o !== 1'b1 || rx_if.ch_startaddr_o !== 12'h100 || rx_if.ch_size_o !== 16'd1536) begin
      tests_failed++;
      $display("FAIL first_arm: en=%b addr=%h size=%0d, required en=1 addr=100 size=1536",
               rx_if.ch_en_o, rx_if.ch_startaddr_o, rx_if.ch_size_o);
    end
    step(1);
    tests_run++;
    if (rx_if.ch_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL first_arm_pulse: ch_en=%b, required 0", rx_if.ch_en_o);
    end
  endtask

  task automatic test_completion();
    send_frame(16'd64);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'd0 || rx_if.rx_size_o !== 16'd64 || rx_if.frame_done_o !== 1'b1 ||
        rx_if.ch_clr_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL completion: ptr=%0d size=%0d done=%b clr=%b, required ptr=0 size=64 done=1 clr=1",
               rx_if.rx_pointer_o, rx_if.rx_size_o, rx_if.frame_done_o, rx_if.ch_clr_o);
    end
    step(1);
    tests_run++;
    if (rx_if.frame_done_o !== 1'b0 || rx_if.ch_clr_o !== 1'b0 || rx_if.ch_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL completion_gap: done=%b clr=%b en=%b, required 0 0 0",
               rx_if.frame_done_o, rx_if.ch_clr_o, rx_if.ch_en_o);
    end
    step(1);
    tests_run++;
    if (rx_if.ch_en_o !== 1'b1 || rx_if.ch_startaddr_o !== 12'h200) begin
      tests_failed++;
      $display("FAIL rearm_latency: en=%b addr=%h, required en=1 addr=200",
               rx_if.ch_en_o, rx_if.ch_startaddr_o);
    end
  endtask

  task automatic test_ring_wrap();
    int n;
    logic [11:0] exp_addr;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    wait_arm(n);
    tests_run++;
    if (n != 3 || rx_if.ch_startaddr_o !== 12'h100) begin
      tests_failed++;
      $display("FAIL wrap_first_arm: cycles=%0d addr=%h, required 3 and 100", n, rx_if.ch_startaddr_o);
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(16'(60 + i));
      tests_run++;
      if (rx_if.rx_pointer_o !== 2'(i) || rx_if.rx_size_o !== 16'(60 + i) || rx_if.frame_done_o !== 1'b1) begin
        tests_failed++;
        $display("FAIL wrap_ptr%0d: ptr=%0d size=%0d done=%b, required ptr=%0d size=%0d done=1",
                 i, rx_if.rx_pointer_o, rx_if.rx_size_o, rx_if.frame_done_o, i, 60 + i);
      end
      wait_arm(n);
      exp_addr = 12'(((i + 1) % 4 + 1) * 256);
      tests_run++;
      if (n != 2 || rx_if.ch_startaddr_o !== exp_addr) begin
        tests_failed++;
        $display("FAIL wrap_arm%0d: cycles=%0d addr=%h, required 2 and %h",
                 i, n, rx_if.ch_startaddr_o, exp_addr);
      end
    end
  endtask

  task automatic test_stall_drop();
    int n;
    logic seen_en;
    desc_full = 4'b0010;
    send_frame(16'd100);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'd0 || rx_if.rx_size_o !== 16'd100) begin
      tests_failed++;
      $display("FAIL stall_pub: ptr=%0d size=%0d, required 0 and 100", rx_if.rx_pointer_o, rx_if.rx_size_o);
    end
    step(1);
    tests_run++;
    if (ring_stall !== 1'b1 || rx_if.ch_en_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_enter: stall=%b en=%b, required 1 and 0", ring_stall, rx_if.ch_en_o);
    end
    seen_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_if.frame_start_i = 1'b1;
      step(1);
      rx_if.frame_start_i = 1'b0;
      if (rx_if.ch_en_o === 1'b1) seen_en = 1'b1;
      step(1);
      if (rx_if.ch_en_o === 1'b1) seen_en = 1'b1;
    end
    tests_run++;
    if (drop_cnt !== 8'd3 || ring_stall !== 1'b1 || seen_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drop: drop=%0d stall=%b arm_seen=%b, required 3 1 0", drop_cnt, ring_stall, seen_en);
    end
    desc_full = 4'b0000;
    step(1);
    tests_run++;
    if (ring_stall !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_exit: stall=%b, required 0", ring_stall);
    end
    wait_arm(n);
    tests_run++;
    if (n != 1 || rx_if.ch_startaddr_o !== 12'h200) begin
      tests_failed++;
      $display("FAIL stall_arm: cycles=%0d addr=%h, required 1 and 200", n, rx_if.ch_startaddr_o);
    end
  endtask

  task automatic test_clip_saturate();
    int n;
    desc_full = 4'b0100;
    send_frame(16'd2000);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'd1 || rx_if.rx_size_o !== 16'd1536) begin
      tests_failed++;
      $display("FAIL clip_len: ptr=%0d size=%0d, required 1 and 1536", rx_if.rx_pointer_o, rx_if.rx_size_o);
    end
    step(1);
    rx_if.frame_start_i = 1'b1;
    step(300);
    rx_if.frame_start_i = 1'b0;
    step(1);
    tests_run++;
    if (drop_cnt !== 8'd255 || ring_stall !== 1'b1) begin
      tests_failed++;
      $display("FAIL drop_sat: drop=%0d stall=%b, required 255 and 1", drop_cnt, ring_stall);
    end
    desc_full = 4'b0000;
    wait_arm(n);
    tests_run++;
    if (n != 2 || rx_if.ch_startaddr_o !== 12'h300) begin
      tests_failed++;
      $display("FAIL sat_arm: cycles=%0d addr=%h, required 2 and 300", n, rx_if.ch_startaddr_o);
    end
  endtask

  task automatic test_disable_resume();
    int n;
    cfg_en = 1'b0;
    step(1);
    tests_run++;
    if (rx_if.ch_clr_o !== 1'b1 || rx_if.frame_done_o !== 1'b0 || rx_if.rx_pointer_o !== 2'd1) begin
      tests_failed++;
      $display("FAIL disable_run: clr=%b done=%b ptr=%0d, required 1 0 1",
               rx_if.ch_clr_o, rx_if.frame_done_o, rx_if.rx_pointer_o);
    end
    wait_arm(n);
    tests_run++;
    if (n != -1 || rx_if.ch_clr_o !== 1'b0 || drop_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL disable_idle: arm_cycles=%0d clr=%b drop=%0d, required -1 0 255",
               n, rx_if.ch_clr_o, drop_cnt);
    end
    cfg_en = 1'b1;
    wait_arm(n);
    tests_run++;
    if (n != 3 || rx_if.ch_startaddr_o !== 12'h300) begin
      tests_failed++;
      $display("FAIL resume_slot: cycles=%0d addr=%h, required 3 and 300", n, rx_if.ch_startaddr_o);
    end
  endtask

  task automatic test_edge_cases();
    int n;
    send_frame(16'd0);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'd2 || rx_if.rx_size_o !== 16'd0 || rx_if.frame_done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_len: ptr=%0d size=%0d done=%b, required 2 0 1",
               rx_if.rx_pointer_o, rx_if.rx_size_o, rx_if.frame_done_o);
    end
    wait_arm(n);
    tests_run++;
    if (n != 2 || rx_if.ch_startaddr_o !== 12'h400) begin
      tests_failed++;
      $display("FAIL zero_len_arm: cycles=%0d addr=%h, required 2 and 400", n, rx_if.ch_startaddr_o);
    end
    cfg_en = 1'b0;
    send_frame(16'd10);
    tests_run++;
    if (rx_if.rx_pointer_o !== 2'd3 || rx_if.rx_size_o !== 16'd10 || rx_if.frame_done_o !== 1'b1 ||
        rx_if.ch_clr_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL valid_with_disable: ptr=%0d size=%0d done=%b clr=%b, required 3 10 1 1",
               rx_if.rx_pointer_o, rx_if.rx_size_o, rx_if.frame_done_o, rx_if.ch_clr_o);
    end
    step(1);
    send_frame(16'd77);
    tests_run++;
    if (rx_if.frame_done_o !== 1'b0 || rx_if.rx_pointer_o !== 2'd3 || rx_if.rx_size_o !== 16'd10) begin
      tests_failed++;
      $display("FAIL valid_outside_run: done=%b ptr=%0d size=%0d, required 0 3 10",
               rx_if.frame_done_o, rx_if.rx_pointer_o, rx_if.rx_size_o);
    end
    cfg_en = 1'b1;
    wait_arm(n);
    tests_run++;
    if (n != 3 || rx_if.ch_startaddr_o !== 12'h100) begin
      tests_failed++;
      $display("FAIL wrap_after_disable: cycles=%0d addr=%h, required 3 and 100", n, rx_if.ch_startaddr_o);
    end
  endtask

  initial begin
    rst                 = 1'b1;
    cfg_en              = 1'b0;
    addr0               = 12'h100;
    addr1               = 12'h200;
    addr2               = 12'h300;
    addr3               = 12'h400;
    desc_full           = 4'b0000;
    rx_if.frame_start_i = 1'b0;
    rx_if.frame_valid_i = 1'b0;
    rx_if.frame_len_i   = 16'd0;

    test_reset();
    test_first_arm();
    test_completion();
    test_ring_wrap();
    test_stall_drop();
    test_clip_saturate();
    test_disable_resume();
    test_edge_cases();

    tests_run++;
    if (both_pulses != 0) begin
      tests_failed++;
      $display("FAIL en_clr_overlap: cycles=%0d, required 0", both_pulses);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
